// File: rtl/apb_regbank_slave.sv
// apb_regbank_slave: APB3/APB4 completer with a small register bank.
//   RW control registers at idx 0..NUM_REGS-3, a W1C IRQ_STATUS register
//   at idx NUM_REGS-2 and a read-only STATUS register at idx NUM_REGS-1.
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   PCLKEN               APB clock enable; the transfer FSM advances only when high
//   PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB/PPROT   APB request (PPROT unused)
//   PRDATA/PREADY/PSLVERR                           APB response
//   status_in            live value returned when STATUS is read
//   irq_event            per-bit set pulses into IRQ_STATUS (sampled every HCLK)
//   ctrl_out             concatenated RW registers, reg0 in the LSBs
//   irq                  registered OR of IRQ_STATUS
module apb_regbank_slave #(
    parameter int ADDRWIDTH   = 16,
    parameter int DATAWIDTH   = 32,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                               HCLK,
    input  logic                               HRESETn,
    input  logic                               PCLKEN,
    input  logic                               PSEL,
    input  logic                               PENABLE,
    input  logic [ADDRWIDTH-1:0]               PADDR,
    input  logic                               PWRITE,
    input  logic [DATAWIDTH-1:0]               PWDATA,
    input  logic [3:0]                         PSTRB,
    input  logic [2:0]                         PPROT,
    output logic [DATAWIDTH-1:0]               PRDATA,
    output logic                               PREADY,
    output logic                               PSLVERR,
    input  logic [DATAWIDTH-1:0]               status_in,
    input  logic [DATAWIDTH-1:0]               irq_event,
    output logic [(NUM_REGS-2)*DATAWIDTH-1:0]  ctrl_out,
    output logic                               irq
);
    localparam int IW = $clog2(NUM_REGS);
    localparam int NC = NUM_REGS - 2;
    localparam logic [IW-1:0] IRQ_IDX = IW'(NUM_REGS - 2);
    localparam logic [IW-1:0] STS_IDX = IW'(NUM_REGS - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                    state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      wr_q, wr_d;
    logic [DATAWIDTH-1:0]      wdata_q, wdata_d;
    logic [3:0]                strb_q, strb_d;
    logic                      err_q, err_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [NC*DATAWIDTH-1:0]   ctrl_q, ctrl_d;
    logic [DATAWIDTH-1:0]      irq_st_q, irq_st_d;
    logic                      irq_q, irq_d;

    logic [IW-1:0]             paddr_idx;
    logic                      setup_err;
    logic                      commit;
    logic [DATAWIDTH-1:0]      mask;
    logic [DATAWIDTH-1:0]      rdata;
    logic                      unused_inputs;

    assign unused_inputs = ^{PPROT, PADDR[1:0]};
    assign paddr_idx     = PADDR[IW+1:2];
    // Any address bit above the index field marks an unmapped address.
    assign setup_err     = (|PADDR[ADDRWIDTH-1:IW+2]) | (PWRITE && paddr_idx == STS_IDX);
    assign mask          = {{8{strb_q[3]}}, {8{strb_q[2]}}, {8{strb_q[1]}}, {8{strb_q[0]}}};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        commit  = 1'b0;
        if (PCLKEN && state_q == ACCESS) begin
            if (!PSEL) begin
                state_d = IDLE;
            end else if (PENABLE) begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                    commit  = wr_q & ~err_q;
                end
            end
        end
        // A setup phase (re)starts a transfer from either state.
        if (PCLKEN && PSEL && !PENABLE) begin
            state_d = ACCESS;
            idx_d   = paddr_idx;
            wr_d    = PWRITE;
            wdata_d = PWDATA;
            strb_d  = PSTRB;
            err_d   = setup_err;
            cnt_d   = 4'(WAIT_CYCLES);
        end
        for (int i = 0; i < NC; i++) begin
            if (commit && idx_q == IW'(i))
                ctrl_d[i*DATAWIDTH +: DATAWIDTH] = (ctrl_q[i*DATAWIDTH +: DATAWIDTH] & ~mask) | (wdata_q & mask);
        end
        // Event set wins over a same-cycle W1C clear.
        irq_st_d = (irq_st_q & ~((commit && idx_q == IRQ_IDX) ? (wdata_q & mask) : '0)) | irq_event;
        irq_d    = |irq_st_q;
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NC; i++) begin
            if (idx_q == IW'(i))
                rdata = ctrl_q[i*DATAWIDTH +: DATAWIDTH];
        end
        if (idx_q == IRQ_IDX)
            rdata = irq_st_q;
        if (idx_q == STS_IDX)
            rdata = status_in;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            ctrl_q   <= '0;
            irq_st_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            strb_q   <= strb_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            irq_st_q <= irq_st_d;
            irq_q    <= irq_d;
        end
    end

    assign PREADY   = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign PSLVERR  = PREADY & err_q;
    assign PRDATA   = (PREADY && !wr_q && !err_q) ? rdata : '0;
    assign ctrl_out = ctrl_q;
    assign irq      = irq_q;
endmodule

// File: tb/tb_apb_regbank_slave.sv
// tb_apb_regbank_slave: self-checking bench for apb_regbank_slave.
//   Hand-computed vector table, hand-written IRQ / PCLKEN / reset sequences,
//   and random transfers checked against a register-array reference model.
module tb_apb_regbank_slave;
    localparam int WC = 2;
    localparam int NR = 8;

    logic         HCLK = 1'b0;
    logic         HRESETn = 1'b0;
    logic         PCLKEN = 1'b1;
    logic         PSEL = 1'b0;
    logic         PENABLE = 1'b0;
    logic [15:0]  PADDR = '0;
    logic         PWRITE = 1'b0;
    logic [31:0]  PWDATA = '0;
    logic [3:0]   PSTRB = '0;
    logic [2:0]   PPROT = '0;
    logic [31:0]  PRDATA;
    logic         PREADY;
    logic         PSLVERR;
    logic [31:0]  status_in = 32'hCAFE0001;
    logic [31:0]  irq_event = '0;
    logic [(NR-2)*32-1:0] ctrl_out;
    logic         irq;

    apb_regbank_slave #(.ADDRWIDTH(16), .DATAWIDTH(32), .NUM_REGS(NR), .WAIT_CYCLES(WC)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .status_in(status_in),
        .irq_event(irq_event), .ctrl_out(ctrl_out), .irq(irq)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int failures = 0;
    logic tog = 1'b0;

    logic [31:0] m_reg [NR-2];
    logic [31:0] m_irq;

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
        PCLKEN = tog ? ~PCLKEN : 1'b1;
    endtask

    // Advance until one HCLK edge with PCLKEN=1 has been consumed.
    task automatic step_en();
        logic en;
        do begin
            en = PCLKEN;
            tick();
        end while (!en);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR - 2; i++) m_reg[i] = '0;
        m_irq = '0;
    endtask

    task automatic model_xfer(input logic w, input logic [15:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] ev,
                              output logic [31:0] rd, output logic err);
        int idx;
        logic [31:0] m;
        idx = int'(a[4:2]);
        err = (a[15:5] != 0) || (w && idx == NR - 1);
        rd = (w || err) ? 32'h0 : (idx == NR - 1) ? status_in : (idx == NR - 2) ? m_irq : m_reg[idx];
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (w && !err) begin
            if (idx < NR - 2) m_reg[idx] = (m_reg[idx] & ~m) | (d & m);
            else if (idx == NR - 2) m_irq = m_irq & ~(d & m);
        end
        m_irq = m_irq | ev;
    endtask

    task automatic xfer(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] ev,
                        output logic [31:0] rd, output logic err, output int waits);
        bit done = 0;
        PSEL = 1; PENABLE = 0; PWRITE = w; PADDR = a; PWDATA = d; PSTRB = s;
        step_en();
        PENABLE = 1;
        waits = 0;
        rd = 'x;
        err = 1'bx;
        for (int k = 0; k < 40 && !done; k++) begin
            if (PREADY) begin
                rd = PRDATA;
                err = PSLVERR;
                irq_event = ev;
                step_en();
                irq_event = '0;
                done = 1;
            end else begin
                step_en();
                waits++;
            end
        end
        PSEL = 0; PENABLE = 0;
        if (!done) begin
            failures++;
            $display("FAIL timeout addr=%h waiting for PREADY", a);
        end
    endtask

    task automatic chk_ctrl(input string nm);
        for (int i = 0; i < NR - 2; i++) chk(nm, ctrl_out[i*32 +: 32], m_reg[i]);
    endtask

    // Transfer predicted by the model, with all response fields checked.
    task automatic mxfer(input string nm, input logic w, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic [31:0] ev);
        logic [31:0] rd, erd;
        logic err, eerr;
        int waits;
        model_xfer(w, a, d, s, ev, erd, eerr);
        xfer(w, a, d, s, ev, rd, err, waits);
        chk({nm, "_rd"}, rd, erd);
        chk({nm, "_err"}, {31'b0, err}, {31'b0, eerr});
        chk({nm, "_waits"}, waits, WC);
    endtask

    initial begin
        vec_t vt [12];
        logic [31:0] rd, erd;
        logic err, eerr;
        int waits;

        vt[0]  = '{1, 16'h0004, 32'h12345678, 4'hF, 32'h0, 0};
        vt[1]  = '{1, 16'h0004, 32'hAABBCCDD, 4'h5, 32'h0, 0};
        vt[2]  = '{0, 16'h0004, 32'h0,        4'h0, 32'h12BB56DD, 0};
        vt[3]  = '{1, 16'h001C, 32'h0000001C, 4'hF, 32'h0, 1};
        vt[4]  = '{0, 16'h001C, 32'h0,        4'h0, 32'hCAFE0001, 0};
        vt[5]  = '{0, 16'h0020, 32'h0,        4'h0, 32'h0, 1};
        vt[6]  = '{1, 16'h0000, 32'h11223344, 4'h0, 32'h0, 0};
        vt[7]  = '{1, 16'h8000, 32'hFFFFFFFF, 4'hF, 32'h0, 1};
        vt[8]  = '{0, 16'h0000, 32'h0,        4'h0, 32'h0, 0};
        vt[9]  = '{1, 16'h0017, 32'hDEADBEEF, 4'hF, 32'h0, 0};
        vt[10] = '{0, 16'h0014, 32'h0,        4'h0, 32'hDEADBEEF, 0};
        vt[11] = '{0, 16'h0018, 32'h0,        4'h0, 32'h0, 0};

        model_reset();
        tick(); tick();
        chk("rst_pready", {31'b0, PREADY}, 0);
        chk("rst_pslverr", {31'b0, PSLVERR}, 0);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_irq", {31'b0, irq}, 0);
        chk("rst_ctrl", {31'b0, |ctrl_out}, 0);
        HRESETn = 1;
        tick();

        for (int i = 0; i < 12; i++) begin
            xfer(vt[i].w, vt[i].a, vt[i].d, vt[i].s, 0, rd, err, waits);
            model_xfer(vt[i].w, vt[i].a, vt[i].d, vt[i].s, 0, erd, eerr);
            chk($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vt[i].exp_err});
            chk($sformatf("vec%0d_waits", i), waits, WC);
            chk_ctrl($sformatf("vec%0d_ctrl", i));
        end
        chk("vec_reg1_hi", ctrl_out[63:32], 32'h12BB56DD);

        // IRQ set, W1C clear, and set-over-clear in the commit cycle.
        irq_event = 32'h8; tick(); irq_event = 0; m_irq = m_irq | 32'h8;
        tick();
        chk("irq_set", {31'b0, irq}, 1);
        mxfer("irq_rd1", 0, 16'h0018, 0, 0, 0);
        chk("irq_rd1_val", m_irq, 32'h8);
        mxfer("irq_clr", 1, 16'h0018, 32'h8, 4'hF, 0);
        tick();
        chk("irq_cleared", {31'b0, irq}, 0);
        mxfer("irq_rd2", 0, 16'h0018, 0, 0, 0);
        irq_event = 32'h8; tick(); irq_event = 0; m_irq = m_irq | 32'h8;
        mxfer("irq_race", 1, 16'h0018, 32'h8, 4'hF, 32'h8);
        tick(); tick();
        chk("irq_race_irq", {31'b0, irq}, 1);
        mxfer("irq_rd3", 0, 16'h0018, 0, 0, 0);
        chk("irq_rd3_val", m_irq, 32'h8);

        // PCLKEN toggling, back-to-back write then read of reg0.
        tog = 1;
        mxfer("tog_wr", 1, 16'h0000, 32'hA5A5A5A5, 4'hF, 0);
        mxfer("tog_rd", 0, 16'h0000, 0, 0, 0);
        chk("tog_rd_val", m_reg[0], 32'hA5A5A5A5);
        tog = 0;
        tick();
        chk_ctrl("tog_ctrl");

        // Reset during the ACCESS wait of a write to reg2.
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 16'h0008; PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
        step_en();
        PENABLE = 1;
        step_en();
        chk("rst_mid_wait", {31'b0, PREADY}, 0);
        HRESETn = 0;
        #1;
        chk("rst_mid_pready", {31'b0, PREADY}, 0);
        chk("rst_mid_pslverr", {31'b0, PSLVERR}, 0);
        chk("rst_mid_reg2", ctrl_out[95:64], 0);
        PSEL = 0; PENABLE = 0;
        model_reset();
        tick();
        HRESETn = 1;
        tick(); tick();
        chk("rst_mid_reg2_after", ctrl_out[95:64], 0);
        mxfer("post_rst_wr", 1, 16'h0008, 32'h00C0FFEE, 4'hF, 0);
        mxfer("post_rst_rd", 0, 16'h0008, 0, 0, 0);
        chk_ctrl("post_rst_ctrl");

        // Random transfers against the model.
        for (int n = 0; n < 80; n++) begin
            logic [15:0] a;
            logic [31:0] ev;
            a = 16'($urandom_range(0, NR - 1) << 2) | 16'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a | (16'h1 << $urandom_range(5, 15));
            status_in = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                ev = $urandom & $urandom;
                irq_event = ev; tick(); irq_event = 0;
                m_irq = m_irq | ev;
            end
            mxfer($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 0);
            tick();
            chk_ctrl($sformatf("rnd%0d_ctrl", n));
            chk($sformatf("rnd%0d_irq", n), {31'b0, irq}, {31'b0, |m_irq});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
